lcdco_bias_cal_ctrl: RTL and testbench

Digital startup and amplitude-calibration controller for the LC-DCO cross-coupled core. It drives the binary-weighted tail-current DAC that feeds the core's bias mirror. The DAC code is stepped until the amplitude detector reports the oscillation inside its window, with a settle wait after every code change. It sits between the chip-level control registers and the DCO analog macro.

---
 rtl/lcdco_bias_cal_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lcdco_bias_cal_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcdco_bias_cal_ctrl.sv
// Purpose : LC-DCO startup / amplitude calibration; steps the tail-current DAC until the detector reports in-window.
// Latency : outputs registered; bias_code moves one cycle after the CHECK decision, each code held SETTLE_CYC+1 cycles.
// Backpr. : none; start is a pulse honoured in IDLE/LOCKED/FAIL, abort (level) wins over start.
//
// Ports: clk, resetn (sync, active-low), start, abort, amp_lo/amp_hi (async detector flags),
//        bias_en, bias_code[CODE_W], busy, done, fail, step_cnt[6].
// Optional macro LCDCO_CAL_TRACK_EN: periodic re-check while LOCKED (every TRACK_PERIOD cycles).
module lcdco_bias_cal_ctrl #(
    parameter int CODE_W       = 6,
    parameter int CODE_INIT    = 32,
    parameter int SETTLE_CYC   = 64,
    parameter int MAX_STEPS    = 48,
    parameter int TRACK_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              amp_lo,
    input  logic              amp_hi,
    output logic              bias_en,
    output logic [CODE_W-1:0] bias_code,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [5:0]        step_cnt
);
    localparam int TMR_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CODE_W-1:0] CODE_MAX   = '1;
    localparam logic [CODE_W-1:0] CODE_START = CODE_W'(CODE_INIT);
    localparam logic [5:0]        STEP_LIMIT = 6'(MAX_STEPS);

    if (CODE_INIT >= (2 ** CODE_W) || SETTLE_CYC < 4 || TRACK_PERIOD < 1) begin : g_bad_param
        $error("lcdco_bias_cal_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_LOCKED, S_FAIL} state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic              lo_s1, lo_s2, hi_s1, hi_s2;

    // Two-flop synchronizers for the asynchronous detector flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lo_s1 <= 1'b0;
            lo_s2 <= 1'b0;
            hi_s1 <= 1'b0;
            hi_s2 <= 1'b0;
        end else begin
            lo_s1 <= amp_lo;
            lo_s2 <= lo_s1;
            hi_s1 <= amp_hi;
            hi_s2 <= hi_s1;
        end
    end

    // Step direction: amp_lo dominates when both flags are set.
    logic              want_up, want_dn, at_limit;
    logic [CODE_W-1:0] code_step;
    always_comb begin
        want_up   = lo_s2;
        want_dn   = !lo_s2 && hi_s2;
        at_limit  = want_up ? (bias_code == CODE_MAX) : (bias_code == '0);
        code_step = want_up ? (bias_code + 1'b1) : (bias_code - 1'b1);
    end

`ifdef LCDCO_CAL_TRACK_EN
    localparam int TRK_W = (TRACK_PERIOD > 2) ? $clog2(TRACK_PERIOD) : 1;
    localparam logic [TRK_W-1:0] TRK_LOAD = TRK_W'(TRACK_PERIOD - 1);
    logic [TRK_W-1:0] track_cnt;
    logic             tracking;   // current SETTLE/CHECK pass was started by a tracking re-check
`else
    logic             tracking;
    assign tracking = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            timer     <= '0;
            bias_en   <= 1'b0;
            bias_code <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            step_cnt  <= '0;
`ifdef LCDCO_CAL_TRACK_EN
            track_cnt <= '0;
            tracking  <= 1'b0;
`endif
        end else if (abort) begin
            // step_cnt is kept so software can read how far the aborted run got.
            state     <= S_IDLE;
            timer     <= '0;
            bias_en   <= 1'b0;
            bias_code <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
`ifdef LCDCO_CAL_TRACK_EN
            tracking  <= 1'b0;
`endif
        end else if (start && (state == S_IDLE || state == S_LOCKED || state == S_FAIL)) begin
            state     <= S_SETTLE;
            timer     <= TMR_LOAD;
            bias_en   <= 1'b1;
            bias_code <= CODE_START;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            step_cnt  <= '0;
`ifdef LCDCO_CAL_TRACK_EN
            tracking  <= 1'b0;
`endif
        end else begin
            case (state)
                S_SETTLE: begin
                    if (timer == '0) state <= S_CHECK;
                    else             timer <= timer - 1'b1;
                end
                S_CHECK: begin
                    if (!want_up && !want_dn) begin
                        state <= S_LOCKED;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef LCDCO_CAL_TRACK_EN
                        track_cnt <= TRK_LOAD;
                        tracking  <= 1'b0;
`endif
                    end else if (at_limit) begin
                        state   <= S_FAIL;
                        fail    <= 1'b1;
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        bias_en <= 1'b0;
                    end else if (tracking) begin
                        // Tracking passes do not consume the calibration step budget.
                        bias_code <= code_step;
                        timer     <= TMR_LOAD;
                        state     <= S_SETTLE;
                    end else if (step_cnt + 6'd1 == STEP_LIMIT) begin
                        // Budget exhausted: count the step but leave the code alone.
                        step_cnt <= step_cnt + 6'd1;
                        state    <= S_FAIL;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        bias_en  <= 1'b0;
                    end else begin
                        step_cnt  <= step_cnt + 6'd1;
                        bias_code <= code_step;
                        timer     <= TMR_LOAD;
                        state     <= S_SETTLE;
                    end
                end
`ifdef LCDCO_CAL_TRACK_EN
                S_LOCKED: begin
                    if (track_cnt != '0) begin
                        track_cnt <= track_cnt - 1'b1;
                    end else if (!want_up && !want_dn) begin
                        track_cnt <= TRK_LOAD;
                    end else if (at_limit) begin
                        state   <= S_FAIL;
                        fail    <= 1'b1;
                        done    <= 1'b0;
                        bias_en <= 1'b0;
                    end else begin
                        bias_code <= code_step;
                        timer     <= TMR_LOAD;
                        tracking  <= 1'b1;
                        state     <= S_SETTLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcdco_bias_cal_ctrl.sv
// Purpose : directed bench for lcdco_bias_cal_ctrl with a behavioural amplitude detector.
// Latency : checks sampled 1 ns after each rising edge.
// Backpr. : n/a; every wait is bounded by a cycle budget.
module tb_lcdco_bias_cal_ctrl;
    localparam int SETTLE_CYC   = 64;
    localparam int TRACK_PERIOD = 1024;

    logic       clk = 1'b0;
    logic       resetn, start, abort, amp_lo, amp_hi;
    logic       bias_en, busy, done, fail;
    logic [5:0] bias_code, step_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // detector model: 0 in window, 1 low while code<target, 2 always high, 3 toggle around 32/33
    int mode = 0;
    int target = 0;
    int last_code = -1;
    int run = 0;
    int min_hold = 9999;
    int min_code = 99;
    int max_code = -1;
    int seq[$];

    always #5 clk = ~clk;

    lcdco_bias_cal_ctrl #(
        .CODE_W(6), .CODE_INIT(32), .SETTLE_CYC(SETTLE_CYC), .MAX_STEPS(48), .TRACK_PERIOD(TRACK_PERIOD)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .amp_lo(amp_lo), .amp_hi(amp_hi),
        .bias_en(bias_en), .bias_code(bias_code), .busy(busy),
        .done(done), .fail(fail), .step_cnt(step_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        seq.delete();
        last_code = -1;
        run = 0;
        min_hold = 9999;
        min_code = 99;
        max_code = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && int'(bias_code) != last_code) begin
            if (last_code >= 0 && run < min_hold) min_hold = run;
            seq.push_back(int'(bias_code));
            last_code = int'(bias_code);
            run = 1;
        end else begin
            run++;
        end
        if (busy) begin
            if (int'(bias_code) < min_code) min_code = int'(bias_code);
            if (int'(bias_code) > max_code) max_code = int'(bias_code);
        end
        case (mode)
            1:       begin amp_lo = (int'(bias_code) < target); amp_hi = 1'b0; end
            2:       begin amp_lo = 1'b0; amp_hi = 1'b1; end
            3:       begin amp_lo = (bias_code <= 6'd32); amp_hi = (bias_code >= 6'd33); end
            default: begin amp_lo = 1'b0; amp_hi = 1'b0; end
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || fail) && n < budget) begin
            tick();
            n++;
        end
        if (!(done || fail)) check("timeout_end", 0, 1);
    endtask

    task automatic wait_code(input int code, input int budget, output int cycles);
        cycles = 0;
        while (int'(bias_code) != code && cycles < budget) begin
            tick();
            cycles++;
        end
        if (int'(bias_code) != code) check("timeout_code", int'(bias_code), code);
    endtask

    initial begin
        int cyc;
        resetn = 1'b0; start = 1'b1; abort = 1'b0; amp_lo = 1'b0; amp_hi = 1'b0;
        tick();
        tick();
        check("rst_bias_en", bias_en, 0);
        check("rst_code", bias_code, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_step", step_cnt, 0);
        start = 1'b0;
        resetn = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);

        // amp low until code 35
        clear_stats();
        mode = 1; target = 35;
        pulse_start();
        check("start_code", bias_code, 32);
        check("start_busy", busy, 1);
        check("start_bias_en", bias_en, 1);
        wait_end(1000);
        check("lo_seq_len", seq.size(), 4);
        for (int i = 0; i < 4 && i < seq.size(); i++) check("lo_seq", seq[i], 32 + i);
        check("lo_done", done, 1);
        check("lo_busy", busy, 0);
        check("lo_step", step_cnt, 3);
        check("lo_code", bias_code, 35);
        check("lo_hold_ok", int'(min_hold >= SETTLE_CYC), 1);
        for (int i = 0; i < 20; i++) tick();
        check("locked_static", bias_code, 35);

        // restart from LOCKED, amp high -> descend to 0
        mode = 2;
        pulse_start();
        check("restart_code", bias_code, 32);
        check("restart_done", done, 0);
        check("restart_step", step_cnt, 0);
        wait_end(3000);
        check("hi_fail", fail, 1);
        check("hi_bias_en", bias_en, 0);
        check("hi_code", bias_code, 0);
        check("hi_step", step_cnt, 32);
        check("hi_busy", busy, 0);

        // toggling detector -> step budget exhausted
        clear_stats();
        mode = 3;
        pulse_start();
        check("tog_start_fail", fail, 0);
        wait_end(4000);
        check("tog_fail", fail, 1);
        check("tog_step", step_cnt, 48);
        check("tog_code", bias_code, 33);
        check("tog_min_code", int'(min_code >= 31), 1);
        check("tog_max_code", int'(max_code <= 33), 1);

        // abort during SETTLE at code 34
        mode = 1; target = 40;
        pulse_start();
        wait_code(34, 400, cyc);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_bias_en", bias_en, 0);
        check("abort_code", bias_code, 0);
        check("abort_busy", busy, 0);
        check("abort_step_kept", step_cnt, 2);
        pulse_start();
        check("abort_restart_code", bias_code, 32);
        check("abort_restart_step", step_cnt, 0);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_prio_busy", busy, 0);
        check("abort_prio_code", bias_code, 0);

`ifdef LCDCO_CAL_TRACK_EN
        begin
            int done_drop = 0;
            mode = 1; target = 40;
            pulse_start();
            wait_end(1000);
            check("trk_lock_code", bias_code, 40);
            check("trk_lock_step", step_cnt, 8);
            mode = 2;
            cyc = 0;
            while (bias_code != 6'd39 && cyc < TRACK_PERIOD + SETTLE_CYC + 4) begin
                tick();
                cyc++;
                if (!done) done_drop++;
            end
            check("trk_code39", bias_code, 39);
            mode = 0;
            for (int i = 0; i < SETTLE_CYC + 8; i++) begin
                tick();
                if (!done) done_drop++;
            end
            check("trk_done_held", done_drop, 0);
            check("trk_busy", busy, 0);
            check("trk_code_final", bias_code, 39);
            check("trk_step_kept", step_cnt, 8);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
